// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Pops FIFO_DATA_WIDTH-bit blocks from the AES output FIFO and streams each
// one as WORDS = FIFO_DATA_WIDTH/AXIS_DATA_WIDTH AXI-Stream beats, most
// significant word first. A transfer of xfer_blocks blocks is started by a
// one-cycle xfer_start pulse. m_axis_tlast marks the final beat of the whole
// transfer, and xfer_done pulses one cycle after that beat is accepted.
//
// Optional feature: define AES_OUT_BSWAP_EN to byte-reverse every beat.
// Only the data path changes; state and handshake timing are identical.
//
// Ports:
//   clk                   in   sole clock, rising edge
//   reset_n               in   asynchronous active-low reset
//   xfer_start            in   one-cycle pulse that starts a transfer
//   xfer_blocks    [31:0] in   block count, sampled on xfer_start
//   out_fifo_read_tvalid  in   output FIFO holds a block
//   out_fifo_data         in   head block of the output FIFO
//   out_fifo_read_tready  out  pop request to the output FIFO (FETCH only)
//   m_axis_tready         in   downstream ready
//   m_axis_tvalid         out  beat valid (SEND only)
//   m_axis_tdata          out  beat data
//   m_axis_tlast          out  final beat of the transfer
//   busy                  out  high outside IDLE
//   xfer_done             out  one-cycle pulse at transfer completion
// ---------------------------------------------------------------------------
module aes_out_serializer #(
    parameter int unsigned FIFO_DATA_WIDTH = 128,
    parameter int unsigned AXIS_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       xfer_start,
    input  logic [31:0]                xfer_blocks,
    input  logic                       out_fifo_read_tvalid,
    input  logic [FIFO_DATA_WIDTH-1:0] out_fifo_data,
    output logic                       out_fifo_read_tready,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       xfer_done
);

    localparam int unsigned WORDS = FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [31:0]                blk_remaining;
    logic [CNT_W-1:0]           word_cnt;
    logic [FIFO_DATA_WIDTH-1:0] shift_reg;
    logic [AXIS_DATA_WIDTH-1:0] head_word;
    logic                       fetch_hs;
    logic                       beat_hs;
    logic                       last_word;
    logic                       last_block;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next           = state;
        out_fifo_read_tready = 1'b0;
        m_axis_tvalid        = 1'b0;
        busy                 = 1'b0;

        fetch_hs   = (state == FETCH) && out_fifo_read_tvalid;
        beat_hs    = (state == SEND) && m_axis_tready;
        last_word  = (word_cnt == LAST_WORD);
        last_block = (blk_remaining == 32'd1);

        case (state)
            IDLE: begin
                // A zero-length request never leaves IDLE; the datapath
                // raises xfer_done for it instead.
                if (xfer_start && (xfer_blocks != '0)) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                out_fifo_read_tready = 1'b1;
                busy                 = 1'b1;
                if (fetch_hs) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                busy          = 1'b1;
                if (beat_hs && last_word) begin
                    state_next = last_block ? IDLE : FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        m_axis_tlast = (state == SEND) && last_word && last_block;
    end

    // ---------------------------------------------------------------------
    // Datapath: block counter, word counter, shift register, done pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_remaining <= '0;
            word_cnt      <= '0;
            shift_reg     <= '0;
            xfer_done     <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer_start) begin
                        if (xfer_blocks != '0) begin
                            blk_remaining <= xfer_blocks;
                        end else begin
                            xfer_done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_hs) begin
                        shift_reg <= out_fifo_data;
                        word_cnt  <= '0;
                    end
                end
                SEND: begin
                    if (beat_hs) begin
                        shift_reg <= shift_reg << AXIS_DATA_WIDTH;
                        word_cnt  <= last_word ? '0 : word_cnt + CNT_W'(1);
                        if (last_word) begin
                            if (last_block) begin
                                blk_remaining <= '0;
                                xfer_done     <= 1'b1;
                            end else begin
                                blk_remaining <= blk_remaining - 32'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Beat data: top word of the shift register, optionally byte-reversed
    // ---------------------------------------------------------------------
    assign head_word = shift_reg[FIFO_DATA_WIDTH-1 -: AXIS_DATA_WIDTH];

`ifdef AES_OUT_BSWAP_EN
    always_comb begin
        m_axis_tdata = '0;
        for (int unsigned b = 0; b < AXIS_DATA_WIDTH / 8; b++) begin
            m_axis_tdata[8*b +: 8] = head_word[AXIS_DATA_WIDTH-8-8*b +: 8];
        end
    end
`else
    always_comb begin
        m_axis_tdata = head_word;
    end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_out_serializer
//
// Directed bench for aes_out_serializer. A queue models the output FIFO and
// a list of expected beats (derived from the pushed blocks) is checked on
// every cycle m_axis_tvalid is high, together with tlast. Cycle stamps of
// beats and of xfer_done check latency. Build with AES_OUT_BSWAP_EN defined
// to check the byte-swapped variant.
// ---------------------------------------------------------------------------
module tb_aes_out_serializer;

    logic         clk;
    logic         reset_n;
    logic         xfer_start;
    logic [31:0]  xfer_blocks;
    logic         out_fifo_read_tvalid;
    logic [127:0] out_fifo_data;
    logic         out_fifo_read_tready;
    logic         m_axis_tready;
    logic         m_axis_tvalid;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tlast;
    logic         busy;
    logic         xfer_done;

    aes_out_serializer #(
        .FIFO_DATA_WIDTH(128),
        .AXIS_DATA_WIDTH(32)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .xfer_start           (xfer_start),
        .xfer_blocks          (xfer_blocks),
        .out_fifo_read_tvalid (out_fifo_read_tvalid),
        .out_fifo_data        (out_fifo_data),
        .out_fifo_read_tready (out_fifo_read_tready),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tlast         (m_axis_tlast),
        .busy                 (busy),
        .xfer_done            (xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [127:0] fifo_q[$];
    logic [31:0]  exp_words[$];
    int           beat_cyc[$];
    int           beat_idx;
    int           done_cnt;
    int           done_cyc;
    int           pop_cnt;
    int           cyc = 0;
    int           start_cyc;
    logic         fifo_en;
    logic         bp_en;
    int           bp_phase;
    logic [3:0]   bp_pat;

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] BLK_C = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

`ifdef AES_OUT_BSWAP_EN
    localparam logic [31:0] FIRST_BEAT_A = 32'h33221100;
`else
    localparam logic [31:0] FIRST_BEAT_A = 32'h00112233;
`endif

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [31:0] beat_of(input logic [31:0] w);
`ifdef AES_OUT_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic fifo_refresh();
        out_fifo_read_tvalid = fifo_en && (fifo_q.size() > 0);
        out_fifo_data        = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_block(input logic [127:0] blk);
        fifo_q.push_back(blk);
        for (int w = 0; w < 4; w++) begin
            exp_words.push_back(beat_of(blk[127-32*w -: 32]));
        end
        fifo_refresh();
    endtask

    task automatic clear_model();
        fifo_q.delete();
        exp_words.delete();
        beat_cyc.delete();
        beat_idx = 0;
        done_cnt = 0;
        done_cyc = -1;
        pop_cnt  = 0;
        fifo_refresh();
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic tick();
        logic pop;
        if (bp_en) begin
            m_axis_tready = bp_pat[bp_phase % 4];
            bp_phase++;
        end
        #1;
        pop = out_fifo_read_tvalid && out_fifo_read_tready;
        if (m_axis_tvalid) begin
            if (beat_idx < exp_words.size()) begin
                check("tdata", m_axis_tdata, exp_words[beat_idx]);
            end else begin
                check("extra_beat", 1, 0);
            end
            check("tlast", m_axis_tlast, beat_idx == exp_words.size() - 1);
        end else begin
            check("tlast_no_valid", m_axis_tlast, 0);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beat_cyc.push_back(cyc);
            beat_idx++;
        end
        if (xfer_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        if (pop) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        cyc++;
        fifo_refresh();
    endtask

    task automatic start_xfer(input logic [31:0] blocks);
        xfer_blocks = blocks;
        xfer_start  = 1'b1;
        start_cyc   = cyc;
        tick();
        xfer_start  = 1'b0;
    endtask

    task automatic run_until_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            check("done_timeout", 0, 1);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tlast"}, m_axis_tlast, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, xfer_done, 0);
        check({tag, "_rd_tready"}, out_fifo_read_tready, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        xfer_start    = 1'b0;
        xfer_blocks   = '0;
        m_axis_tready = 1'b1;
        fifo_en       = 1'b1;
        bp_en         = 1'b0;
        bp_phase      = 0;
        bp_pat        = 4'b1001;   // bit index = phase: 1,0,0,1
        clear_model();

        // Reset state
        @(negedge clk);
        #1;
        check_all_low("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single block, tready held high
        clear_model();
        push_block(BLK_A);
        start_xfer(1);
        #1;
        check("single_fetch_busy", busy, 1);
        check("single_fetch_rd_tready", out_fifo_read_tready, 1);
        check("single_fetch_tvalid", m_axis_tvalid, 0);
        tick();
        #1;
        check("single_first_beat", m_axis_tdata, FIRST_BEAT_A);
        run_until_done(20);
        check("single_beats", beat_idx, 4);
        check("single_first_lat", beat_cyc[0] - start_cyc, 2);
        check("single_done_lat", done_cyc - start_cyc, 6);
        check("single_pops", pop_cnt, 1);
        tick();
        check("single_done_once", done_cnt, 1);
        check("single_idle", busy, 0);

        // Three blocks, FIFO pre-filled; a start while busy is ignored
        clear_model();
        push_block(BLK_A);
        push_block(BLK_B);
        push_block(BLK_C);
        start_xfer(3);
        tick();
        tick();
        tick();
        xfer_blocks = 7;
        xfer_start  = 1'b1;
        tick();
        xfer_start  = 1'b0;
        run_until_done(40);
        check("three_beats", beat_idx, 12);
        check("three_gap1", beat_cyc[4] - beat_cyc[3], 2);
        check("three_gap2", beat_cyc[8] - beat_cyc[7], 2);
        check("three_span", beat_cyc[11] - beat_cyc[0], 13);
        check("three_done_lat", done_cyc - start_cyc, 16);
        check("three_pops", pop_cnt, 3);
        tick();
        tick();
        check("three_done_once", done_cnt, 1);
        check("three_idle", busy, 0);

        // Backpressure: tready 1,0,0,1,...
        clear_model();
        push_block(BLK_C);
        push_block(BLK_B);
        bp_en    = 1'b1;
        bp_phase = 0;
        start_xfer(2);
        run_until_done(100);
        bp_en         = 1'b0;
        m_axis_tready = 1'b1;
        check("bp_beats", beat_idx, 8);
        check("bp_pops", pop_cnt, 2);
        tick();
        check("bp_done_once", done_cnt, 1);

        // Empty FIFO for 10 cycles, then data arrives
        clear_model();
        fifo_en = 1'b0;
        push_block(BLK_B);
        start_xfer(1);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("empty_tvalid", m_axis_tvalid, 0);
            check("empty_rd_tready", out_fifo_read_tready, 1);
            tick();
        end
        check("empty_no_pop", pop_cnt, 0);
        fifo_en = 1'b1;
        fifo_refresh();
        run_until_done(20);
        check("empty_beats", beat_idx, 4);
        check("empty_pops", pop_cnt, 1);
        tick();

        // Reset after beat 2 of block 1 of 2
        clear_model();
        push_block(BLK_A);
        push_block(BLK_C);
        start_xfer(2);
        tick();
        tick();
        tick();
        check("rst_beats_before", beat_idx, 2);
        reset_n = 1'b0;
        #1;
        check_all_low("rst_mid");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rst_stays_idle", busy, 0);
            tick();
        end
        check("rst_no_done", done_cnt, 0);
        check("rst_no_more_beats", beat_idx, 2);

        // Zero-length transfer
        clear_model();
        start_xfer(0);
        #1;
        check("zero_done", xfer_done, 1);
        check("zero_busy", busy, 0);
        check("zero_rd_tready", out_fifo_read_tready, 0);
        tick();
        #1;
        check("zero_done_clear", xfer_done, 0);
        tick();
        check("zero_done_once", done_cnt, 1);
        check("zero_no_beats", beat_idx, 0);
        check("zero_no_pops", pop_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
